// File: rtl/line_buf_pkg.sv
// Shared helpers for the line window buffer: address sizing, width clamping
// and tap slice positions.
package line_buf_pkg;

  localparam int TAP_CUR = 0;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Zero or oversized widths fall back to the full RAM depth.
  function automatic int clamp_width(input int w, input int max_w);
    return (w == 0 || w > max_w) ? max_w : w;
  endfunction

  function automatic int tap_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/line_window_buffer_ram.sv
// Single-port line RAM with asynchronous read, so the read value is the old
// contents at the address being written this cycle.
module line_ram
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1920,
  localparam int AW        = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign o_rdata = mem_q[i_addr];

  always_ff @(posedge clk) begin
    if (i_en) mem_q[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/line_window_buffer.sv
// Vertical NUM_TAPS-line pixel column for window filters. Define
// LINE_WINDOW_BORDER_REPLICATE_EN to replicate the oldest valid line into taps not yet filled.
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int MAX_LINE_WIDTH = 1920,
  parameter int NUM_TAPS       = 3,
  localparam int AW            = addr_w(MAX_LINE_WIDTH),
  localparam int WW            = $clog2(MAX_LINE_WIDTH + 1),
  localparam int LW            = addr_w(NUM_TAPS)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_ena,
  input  logic                           i_sof,
  input  logic [WW-1:0]                  i_line_width,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] o_taps,
  output logic                           o_valid,
  output logic [AW-1:0]                  o_col
);

  logic [AW-1:0] w_ptr_q, w_ptr_d, col;
  logic [LW-1:0] line_cnt_q, line_cnt_d, lcur;
  logic [WW-1:0] width_q, width_d;
  logic          wrap;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] rd, taps_d, taps_q;
  logic          valid_q;

  // rd[0] is the incoming pixel; rd[k] is the column k lines back.
  assign rd[TAP_CUR] = i_data;

  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_ram
    line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_LINE_WIDTH)) u_ram (
      .clk    (clk),
      .i_en   (i_ena),
      .i_addr (col),
      .i_wdata(rd[k-1]),
      .o_rdata(rd[k])
    );
  end

  always_comb begin
    col     = w_ptr_q;
    lcur    = line_cnt_q;
    width_d = width_q;
    if (i_sof) begin
      col     = '0;
      lcur    = '0;
      width_d = WW'(clamp_width(int'(i_line_width), MAX_LINE_WIDTH));
    end
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (int'(lcur) >= k) taps_d[k] = rd[k];
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
      else                 taps_d[k] = rd[lcur];
`else
      else                 taps_d[k] = '0;
`endif
    end
    wrap       = (int'(col) == int'(width_d) - 1);
    w_ptr_d    = wrap ? '0 : col + AW'(1);
    line_cnt_d = (wrap && int'(lcur) != NUM_TAPS - 1) ? lcur + LW'(1) : lcur;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      w_ptr_q    <= '0;
      line_cnt_q <= '0;
      width_q    <= WW'(MAX_LINE_WIDTH);
      taps_q     <= '0;
      valid_q    <= 1'b0;
      o_col      <= '0;
    end else if (i_ena) begin
      w_ptr_q    <= w_ptr_d;
      line_cnt_q <= line_cnt_d;
      width_q    <= width_d;
      taps_q     <= taps_d;
      valid_q    <= (int'(lcur) >= NUM_TAPS - 1);
      o_col      <= col;
    end else begin
      valid_q    <= 1'b0;
    end
  end

  assign o_taps  = taps_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed plus randomized bench for line_window_buffer against a line-history
// reference model (frame lines indexed by absolute line number).
module tb_line_window_buffer;
  localparam int DW = 8, MAXW = 16, NT = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          i_ena = 1'b0, i_sof = 1'b0;
  logic [4:0]    i_line_width = '0;
  logic [DW-1:0] i_data = '0;
  logic [NT*DW-1:0] o_taps;
  logic          o_valid;
  logic [3:0]    o_col;

  int checks = 0, errors = 0;

  // reference state
  int mline [NT][MAXW];
  int mc = 0, lnum = 0, mw = MAXW;
  logic [NT*DW-1:0] exp_taps = '0;
  logic             exp_valid = 1'b0;
  logic [3:0]       exp_col = '0;

  line_window_buffer #(.DATA_WIDTH(DW), .MAX_LINE_WIDTH(MAXW), .NUM_TAPS(NT)) dut (
    .clk(clk), .n_rst(n_rst), .i_ena(i_ena), .i_sof(i_sof),
    .i_line_width(i_line_width), .i_data(i_data),
    .o_taps(o_taps), .o_valid(o_valid), .o_col(o_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".taps"}, 32'(o_taps), 32'(exp_taps));
    chk({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
    chk({tag, ".col"}, 32'(o_col), 32'(exp_col));
  endtask

  task automatic step(input bit ena, input bit sof, input int w, input int data, input string tag);
    int c, lv, v;
    @(negedge clk);
    i_ena = ena; i_sof = sof; i_line_width = w[4:0]; i_data = data[7:0];
    if (ena) begin
      if (sof) begin
        mc = 0; lnum = 0;
        mw = (w[4:0] == 0 || w[4:0] > MAXW) ? MAXW : int'(w[4:0]);
      end
      c  = mc;
      lv = (lnum < NT - 1) ? lnum : NT - 1;
      for (int k = 0; k < NT; k++) begin
        if (k == 0)         v = data & 8'hff;
        else if (lnum >= k) v = mline[(lnum - k) % NT][c];
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
        else if (lv == 0)   v = data & 8'hff;
        else                v = mline[(lnum - lv) % NT][c];
`else
        else                v = 0;
`endif
        exp_taps[k*DW +: DW] = v[7:0];
      end
      exp_valid = (lnum >= NT - 1);
      exp_col   = c[3:0];
      mline[lnum % NT][c] = data & 8'hff;
      if (c == mw - 1) begin mc = 0; lnum++; end
      else mc = c + 1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk_model(tag);
  endtask

  task automatic do_reset;
    @(negedge clk);
    n_rst = 1'b0; i_ena = 1'b1; i_sof = 1'b0; i_data = 8'hAA;
    @(posedge clk); #1;
    chk("rst.taps", 32'(o_taps), 32'h0);
    chk("rst.valid", 32'(o_valid), 32'h0);
    chk("rst.col", 32'(o_col), 32'h0);
    n_rst = 1'b1; i_ena = 1'b0;
    mc = 0; lnum = 0; mw = MAXW;
    exp_taps = '0; exp_valid = 1'b0; exp_col = '0;
  endtask

  initial begin
    // basic stream, W=4, with a 3-cycle gap between pixels 9 and 10
    do_reset();
    for (int p = 1; p <= 12; p++) begin
      step(1'b1, p == 1, 4, p, "stream");
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
      if (p == 2) chk("rep.p2", 32'(o_taps), 32'h020202);
      if (p == 6) chk("rep.p6", 32'(o_taps), 32'h020206);
`else
      if (p == 5) begin
        chk("p5.taps", 32'(o_taps), 32'h000105);
        chk("p5.valid", 32'(o_valid), 32'h0);
      end
`endif
      if (p == 9) begin
        chk("p9.taps", 32'(o_taps), 32'h010509);
        chk("p9.valid", 32'(o_valid), 32'h1);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 4, 8'hEE, "gap");
          chk("gap.valid", 32'(o_valid), 32'h0);
          chk("gap.taps", 32'(o_taps), 32'h010509);
        end
      end
      if (p == 10) chk("p10.taps", 32'(o_taps), 32'h02060A);
      if (p == 12) begin
        chk("p12.taps", 32'(o_taps), 32'h04080C);
        chk("p12.col", 32'(o_col), 32'h3);
      end
    end

    // start of frame mid-line with a narrower width
    for (int p = 1; p <= 11; p++) begin
      step(1'b1, p == 1 || p == 7, (p == 7) ? 2 : 4, p, "midsof");
      if (p == 7) begin
        chk("sof7.col", 32'(o_col), 32'h0);
        chk("sof7.valid", 32'(o_valid), 32'h0);
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
        chk("sof7.taps", 32'(o_taps), 32'h070707);
`else
        chk("sof7.taps", 32'(o_taps), 32'h000007);
`endif
      end
      if (p == 11) chk("sof11.valid", 32'(o_valid), 32'h1);
    end

    // width 0 clamps to the full depth
    for (int p = 1; p <= 17; p++) begin
      step(1'b1, p == 1, 0, p + 100, "w0");
      if (p == 16) chk("w0.col15", 32'(o_col), 32'hF);
      if (p == 17) chk("w0.wrap", 32'(o_col), 32'h0);
    end

    // width 1: every pixel is a line
    for (int p = 1; p <= 5; p++) begin
      step(1'b1, p == 1, 1, p + 50, "w1");
      if (p >= 3) begin
        chk("w1.valid", 32'(o_valid), 32'h1);
        chk("w1.taps", 32'(o_taps), {8'h0, 8'(p + 48), 8'(p + 49), 8'(p + 50)});
      end
    end

    // reset mid-frame, then a pixel without start of frame
    for (int p = 1; p <= 6; p++) step(1'b1, p == 1, 4, p + 20, "prerst");
    do_reset();
    step(1'b1, 1'b0, 4, 77, "postrst");
    chk("postrst.col", 32'(o_col), 32'h0);
    chk("postrst.valid", 32'(o_valid), 32'h0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit ena, sof;
      ena = ($urandom_range(0, 9) < 8);
      sof = ($urandom_range(0, 39) == 0);
      step(ena, sof, $urandom_range(0, 20), $urandom_range(0, 255), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
